// File: rtl/perfil_pkg.sv
// perfil_pkg: profile width, null profile, default ack timeout and FSM state encoding
// shared by the profile arbiter and its round-robin selector.
package perfil_pkg;

  localparam int PERFIL_W = 3;
  localparam logic [PERFIL_W-1:0] PERFIL_NULO = 3'b000;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PRESENT = 2'd2,
    RELEASE = 2'd3
  } estado_t;

endpackage

// File: rtl/perfil_rr_sel.sv
// perfil_rr_sel: combinational round-robin pick, returning the first requester at or after ptr
// (wrapping modulo N_IF) plus a flag telling whether anybody requests at all.
module perfil_rr_sel
  import perfil_pkg::*;
#(
  parameter int N_IF  = 4,
  parameter int IDX_W = $clog2(N_IF)
) (
  input  logic [N_IF-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] sel,
  output logic             any
);

  assign any = |req;

  // Scan from farthest to nearest so the requester closest to ptr overwrites the rest.
  always_comb begin
    sel = {IDX_W{1'b0}};
    for (int i = N_IF - 1; i >= 0; i--) begin
      sel = req[IDX_W'((int'(ptr) + i) % N_IF)] ? IDX_W'((int'(ptr) + i) % N_IF) : sel;
    end
  end

endmodule

// File: rtl/perfil_arbitro.sv
// perfil_arbitro: round-robin arbiter putting one interface's profile on the shared bus with a
// valid/ack handshake. Define PERFIL_TIMEOUT_EN to abandon presentations not acked in TIMEOUT_CYC cycles.
module perfil_arbitro
  import perfil_pkg::*;
#(
  parameter int N_IF        = 4,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IF-1:0]          req,
  input  logic [N_IF*PERFIL_W-1:0] perfil_in,
  input  logic [N_IF-1:0]          valido,
  input  logic                     ack,
  output logic [N_IF-1:0]          grant,
  output logic [PERFIL_W-1:0]      perfil_out,
  output logic                     perfil_vld,
  output logic                     erro,
  output logic                     ocupado
);

  localparam int IDX_W = $clog2(N_IF);

  if (N_IF < 2 || N_IF > 8 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("perfil_arbitro: N_IF must be 2..8 and TIMEOUT_CYC at least 2");
  end

  estado_t               state_r;
  logic [IDX_W-1:0]      ptr_r;
  logic [IDX_W-1:0]      sel_r;
  logic [IDX_W-1:0]      sel_s;
  logic [IDX_W-1:0]      ptr_next_s;
  logic                  any_s;
  logic [N_IF-1:0]       grant_r;
  logic [PERFIL_W-1:0]   perfil_out_r;
  logic                  perfil_vld_r;
  logic                  erro_r;
  logic                  ocupado_r;
  logic [PERFIL_W-1:0]   perfil_arr_s [N_IF];

`ifdef PERFIL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0]      cnt_r;
`endif

  for (genvar i = 0; i < N_IF; i++) begin : g_split
    assign perfil_arr_s[i] = perfil_in[i*PERFIL_W +: PERFIL_W];
  end

  perfil_rr_sel #(
    .N_IF  (N_IF),
    .IDX_W (IDX_W)
  ) u_rr_sel (
    .req (req),
    .ptr (ptr_r),
    .sel (sel_s),
    .any (any_s)
  );

  // Once an interface has been served it drops to the lowest priority.
  assign ptr_next_s = (sel_r == IDX_W'(N_IF - 1)) ? {IDX_W{1'b0}} : sel_r + IDX_W'(1);

  // Sequencer FSM; grant and erro are one-cycle pulses, the profile is held until released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      ptr_r        <= {IDX_W{1'b0}};
      sel_r        <= {IDX_W{1'b0}};
      grant_r      <= {N_IF{1'b0}};
      perfil_out_r <= PERFIL_NULO;
      perfil_vld_r <= 1'b0;
      erro_r       <= 1'b0;
      ocupado_r    <= 1'b0;
`ifdef PERFIL_TIMEOUT_EN
      cnt_r        <= {CNT_W{1'b0}};
`endif
    end else begin
      grant_r <= {N_IF{1'b0}};
      erro_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_s) begin
            sel_r     <= sel_s;
            grant_r   <= {{(N_IF-1){1'b0}}, 1'b1} << sel_s;
            ocupado_r <= 1'b1;
            state_r   <= CAPTURE;
          end else begin
            state_r <= IDLE;
          end
        end
        CAPTURE: begin
          if (valido[sel_r]) begin
            perfil_out_r <= perfil_arr_s[sel_r];
            perfil_vld_r <= 1'b1;
            state_r      <= PRESENT;
`ifdef PERFIL_TIMEOUT_EN
            cnt_r        <= {CNT_W{1'b0}};
`endif
          end else begin
            erro_r    <= 1'b1;
            ptr_r     <= ptr_next_s;
            ocupado_r <= 1'b0;
            state_r   <= IDLE;
          end
        end
        PRESENT: begin
          if (ack) begin
            perfil_vld_r <= 1'b0;
            perfil_out_r <= PERFIL_NULO;
            ptr_r        <= ptr_next_s;
            state_r      <= RELEASE;
          end
`ifdef PERFIL_TIMEOUT_EN
          else if (cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
            perfil_vld_r <= 1'b0;
            perfil_out_r <= PERFIL_NULO;
            erro_r       <= 1'b1;
            ptr_r        <= ptr_next_s;
            state_r      <= RELEASE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
`else
          else begin
            state_r <= PRESENT;
          end
`endif
        end
        RELEASE: begin
          ocupado_r <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          perfil_vld_r <= 1'b0;
          perfil_out_r <= PERFIL_NULO;
          ocupado_r    <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign grant      = grant_r;
  assign perfil_out = perfil_out_r;
  assign perfil_vld = perfil_vld_r;
  assign erro       = erro_r;
  assign ocupado    = ocupado_r;

endmodule

// File: tb/tb_perfil_arbitro.sv
// tb_perfil_arbitro: randomized transactions against a transaction-level round-robin model;
// expected outcomes are queued by the stimulus and consumed by an independent monitor.
module tb_perfil_arbitro;
  import perfil_pkg::*;

  localparam int N  = 4;
  localparam int IW = $clog2(N);
  localparam int TO = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  ack;
  logic [N-1:0]          req;
  logic [N-1:0]          valido;
  logic [N*PERFIL_W-1:0] perfil_in;
  logic [N-1:0]          grant;
  logic [PERFIL_W-1:0]   perfil_out;
  logic                  perfil_vld;
  logic                  erro;
  logic                  ocupado;

  typedef struct packed {
    logic [N-1:0]        grant;
    logic                is_err;
    logic [PERFIL_W-1:0] perfil;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mptr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  perfil_arbitro #(.N_IF(N), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .perfil_in  (perfil_in),
    .valido     (valido),
    .ack        (ack),
    .grant      (grant),
    .perfil_out (perfil_out),
    .perfil_vld (perfil_vld),
    .erro       (erro),
    .ocupado    (ocupado)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  // Reference rule: first requester scanning ptr, ptr+1, ... modulo N.
  function automatic int winner(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[IW'((mptr + k) % N)]) return (mptr + k) % N;
    end
    return -1;
  endfunction

  task automatic issue(input logic [N-1:0] r, input logic [N-1:0] v, input logic [N*PERFIL_W-1:0] p);
    exp_t e;
    int   w;
    w = winner(r);
    req = r;
    valido = v;
    perfil_in = p;
    e.grant  = N'({{(N-1){1'b0}}, 1'b1} << w);
    e.is_err = ~v[IW'(w)];
    e.perfil = v[IW'(w)] ? PERFIL_W'(p >> (w * PERFIL_W)) : PERFIL_NULO;
    expq.push_back(e);
    mptr = (w + 1) % N;
  endtask

  task automatic issue_rand();
    logic [N-1:0] r;
    logic [N-1:0] v;
    r = N'($urandom_range(1, (1 << N) - 1));
    v = N'($urandom) | N'($urandom);
    issue(r, v, (N*PERFIL_W)'($urandom));
  endtask

  task automatic finish_txn(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!perfil_vld && !erro && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (!perfil_vld && !erro) begin
      checks++;
      errors++;
      $display("FAIL txn_wait actual=no_response required=response_within_12_cycles");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
    end
    ok = perfil_vld;
    req = '0;
    valido = N'($urandom);
    perfil_in = (N*PERFIL_W)'($urandom);
  endtask

  task automatic do_ack(input int d, input bit ov, output bit issued);
    issued = 1'b0;
`ifdef PERFIL_TIMEOUT_EN
    if (d >= TO) begin
      int n;
      n = 0;
      while (perfil_vld && n < TO + 4) begin
        @(negedge clk);
        n++;
      end
      check("timeout_cycles", 32'(n), 32'(TO));
      check("timeout_erro", 32'(erro), 32'd1);
      check("timeout_perfil", 32'(perfil_out), 32'(PERFIL_NULO));
      @(negedge clk);
      check("timeout_pulse", 32'(erro), 32'd0);
      return;
    end
`endif
    for (int i = 0; i < d; i++) @(negedge clk);
    ack = 1'b1;
    if (ov) begin
      issue_rand();
      issued = 1'b1;
    end
    @(negedge clk);
    ack = 1'b0;
    check("ack_vld", 32'(perfil_vld), 32'd0);
    check("ack_erro", 32'(erro), 32'd0);
    check("ack_perfil", 32'(perfil_out), 32'(PERFIL_NULO));
  endtask

  // Monitor: pops one expectation per grant and checks the outcome and the held profile.
  exp_t                cur;
  int                  prev_gcyc = -100;
  bit                  prev_ok = 1'b0;
  bit                  awaiting = 1'b0;
  bit                  vld_q = 1'b0;
  logic [PERFIL_W-1:0] held = '0;

  always @(negedge clk) begin
    if (rst) begin
      awaiting  = 1'b0;
      vld_q     = 1'b0;
      prev_gcyc = -100;
    end else begin
      if (awaiting) begin
        awaiting = 1'b0;
        check("grant_pulse", 32'(grant), 32'd0);
        check("outcome_erro", 32'(erro), 32'(cur.is_err));
        check("outcome_vld", 32'(perfil_vld), 32'(!cur.is_err));
        check("outcome_perfil", 32'(perfil_out), 32'(cur.perfil));
        check("outcome_ocupado", 32'(ocupado), 32'(!cur.is_err));
        prev_ok = !cur.is_err;
        held = cur.perfil;
      end else if (grant != '0) begin
        if (expq.size() == 0) begin
          check("unexpected_grant", 32'(grant), 32'd0);
        end else begin
          cur = expq.pop_front();
          check("grant", 32'(grant), 32'(cur.grant));
          check("grant_ocupado", 32'(ocupado), 32'd1);
          if (prev_gcyc >= 0) check("grant_spacing", 32'((cyc - prev_gcyc) >= (prev_ok ? 4 : 2)), 32'd1);
          prev_gcyc = cyc;
          awaiting = 1'b1;
        end
      end else if (vld_q && perfil_vld) begin
        check("hold_perfil", 32'(perfil_out), 32'(held));
      end else if (vld_q && !perfil_vld) begin
        check("release_perfil", 32'(perfil_out), 32'(PERFIL_NULO));
      end
      vld_q = perfil_vld;
    end
  end

  initial begin
    bit ok;
    bit pending;
    int d;
    rst = 1'b0; ack = 1'b0; req = '0; valido = '0; perfil_in = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_perfil", 32'(perfil_out), 32'(PERFIL_NULO));
    check("rst_vld", 32'(perfil_vld), 32'd0);
    check("rst_erro", 32'(erro), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Single request with latency checks.
    issue(4'b0001, 4'b0001, {3'b000, 3'b000, 3'b000, 3'b101});
    @(negedge clk);
    check("lat_grant", 32'(grant), 32'(4'b0001));
    finish_txn(ok);
    check("lat_vld", 32'(ok), 32'd1);
    do_ack(0, 1'b0, pending);

    // All requesting: rotation order.
    for (int k = 0; k < 5; k++) begin
      issue(4'b1111, 4'b1111, {3'b100, 3'b011, 3'b010, 3'b001});
      finish_txn(ok);
      do_ack(0, 1'b0, pending);
    end

    // Invalid profile rejected, then the same interface served.
    issue(4'b0100, 4'b0000, (N*PERFIL_W)'($urandom));
    finish_txn(ok);
    check("err_no_vld", 32'(ok), 32'd0);
    @(negedge clk);
    issue(4'b0100, 4'b0100, {3'b000, 3'b111, 3'b000, 3'b000});
    finish_txn(ok);
    do_ack(1, 1'b0, pending);

    // Reset while presenting: pointer returns to 0.
    issue(4'b0010, 4'b0010, {3'b000, 3'b000, 3'b011, 3'b000});
    finish_txn(ok);
    do_ack(0, 1'b0, pending);
    issue(4'b1000, 4'b1000, {3'b110, 3'b000, 3'b000, 3'b000});
    finish_txn(ok);
    check("pre_rst_perfil", 32'(perfil_out), 32'(3'b110));
    #2 rst = 1'b1;
    #1;
    check("async_rst_perfil", 32'(perfil_out), 32'(PERFIL_NULO));
    check("async_rst_vld", 32'(perfil_vld), 32'd0);
    check("async_rst_grant", 32'(grant), 32'd0);
    check("async_rst_ocupado", 32'(ocupado), 32'd0);
    mptr = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    issue(4'b1010, 4'b1010, {3'b001, 3'b000, 3'b101, 3'b000});
    finish_txn(ok);
    do_ack(0, 1'b0, pending);

`ifdef PERFIL_TIMEOUT_EN
    issue(4'b0001, 4'b0001, {3'b000, 3'b000, 3'b000, 3'b011});
    finish_txn(ok);
    do_ack(TO + 4, 1'b0, pending);
    issue(4'b0001, 4'b0001, {3'b000, 3'b000, 3'b000, 3'b010});
    finish_txn(ok);
    do_ack(TO - 1, 1'b0, pending);
`endif

    // Randomized traffic, including ack coinciding with the next request.
    pending = 1'b0;
    for (int t = 0; t < 150; t++) begin
      if (!pending) issue_rand();
      finish_txn(ok);
      pending = 1'b0;
      if (ok) begin
        d = int'($urandom_range(0, 3));
`ifdef PERFIL_TIMEOUT_EN
        if ($urandom_range(0, 9) == 0) d = (($urandom & 32'd1) != 32'd0) ? TO - 1 : TO + 4;
`endif
        do_ack(d, ($urandom & 32'd1) != 32'd0, pending);
      end
    end
    if (pending) begin
      finish_txn(ok);
      if (ok) do_ack(0, 1'b0, pending);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
